// File: rtl/bru_pkg.sv
// Shared types and helpers for the branch resolve queue.
// Statistics counters are enabled with BRU_STATS_EN.
package bru_pkg;

    localparam int PC_W   = 10;
    localparam int HIST_W = 3;
    localparam int STAT_W = 16;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            predicted;
    } bru_entry_t;

    // Taken when at least two of the recorded outcomes were taken.
    function automatic logic bru_predict(
        input logic [HIST_W-1:0] hist,
        input logic              hit
    );
        return hit && ($countones(hist) >= 2);
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// Circular buffer of in-flight predictions.
// Clear takes priority over push and pop.
module bru_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (clear) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

    assign head_data = mem[head];
    assign count     = cnt;
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch prediction/resolution queue: predicts, tracks and resolves branches.
// Define BRU_STATS_EN to build the saturating statistics counters.
module branch_resolve_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 10,
    parameter int HIST_W = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_req,
    input  logic [PC_W-1:0]            pred_pc,
    output logic                       pred_ready,
    output logic                       pred_out_valid,
    output logic                       pred_out_taken,
    output logic [PC_W-1:0]            cache_rd_pc,
    input  logic [HIST_W-1:0]          cache_rd_history,
    input  logic                       cache_rd_hit,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_err,
    output logic                       mispredict,
    output logic [PC_W-1:0]            mispredict_pc,
    output logic                       cache_we,
    output logic [PC_W-1:0]            cache_upd_pc,
    output logic                       cache_branch_taken,
    input  logic                       cache_evict,
    output logic [bru_pkg::STAT_W-1:0] stat_resolved,
    output logic [bru_pkg::STAT_W-1:0] stat_mispredict,
    output logic [bru_pkg::STAT_W-1:0] stat_evict
);
    import bru_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W:0]   head_data;
    logic [PC_W-1:0] head_pc;
    logic            head_pred;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            accept;
    logic            predict;
    logic            do_pop;
    logic            miss;

    assign predict   = bru_predict(cache_rd_history, cache_rd_hit);
    assign pred_ready = rst_n && !full;
    assign accept    = pred_req && pred_ready;
    assign do_pop    = res_valid && (count != '0);
    assign head_pc   = head_data[PC_W:1];
    assign head_pred = head_data[0];
    assign miss      = do_pop && (res_taken != head_pred);
    assign cache_rd_pc = pred_pc;

    // A mispredict flushes everything, including a same-cycle push.
    bru_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .pop       (do_pop),
        .clear     (miss),
        .push_data ({pred_pc, predict}),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid     <= 1'b0;
            pred_out_taken     <= 1'b0;
            res_err            <= 1'b0;
            mispredict         <= 1'b0;
            mispredict_pc      <= '0;
            cache_we           <= 1'b0;
            cache_upd_pc       <= '0;
            cache_branch_taken <= 1'b0;
        end else begin
            pred_out_valid <= accept;
            pred_out_taken <= accept && predict;
            res_err        <= res_valid && empty;
            cache_we       <= do_pop;
            mispredict     <= miss;
            if (do_pop) begin
                cache_upd_pc       <= head_pc;
                cache_branch_taken <= res_taken;
            end
            if (miss) mispredict_pc <= head_pc;
        end
    end

`ifdef BRU_STATS_EN
    logic [STAT_W-1:0] n_res;
    logic [STAT_W-1:0] n_mp;
    logic [STAT_W-1:0] n_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_res <= '0;
            n_mp  <= '0;
            n_ev  <= '0;
        end else begin
            if (do_pop && n_res != '1) n_res <= n_res + 1'b1;
            if (miss && n_mp != '1)    n_mp  <= n_mp + 1'b1;
            if (cache_we && cache_evict && n_ev != '1)
                n_ev <= n_ev + 1'b1;
        end
    end

    assign stat_resolved   = n_res;
    assign stat_mispredict = n_mp;
    assign stat_evict      = n_ev;
`else
    logic unused_evict;
    assign unused_evict    = cache_evict;
    assign stat_resolved   = '0;
    assign stat_mispredict = '0;
    assign stat_evict      = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: queue-based model plus
// directed vectors with literal expectations.
module tb_branch_resolve_queue;
    import bru_pkg::*;

    localparam int DEPTH = 4;
    localparam int PW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pred_req = 1'b0;
    logic [PW-1:0] pred_pc = '0;
    logic          pred_ready;
    logic          pred_out_valid;
    logic          pred_out_taken;
    logic [PW-1:0] cache_rd_pc;
    logic [2:0]    cache_rd_history = '0;
    logic          cache_rd_hit = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_taken = 1'b0;
    logic          res_err;
    logic          mispredict;
    logic [PW-1:0] mispredict_pc;
    logic          cache_we;
    logic [PW-1:0] cache_upd_pc;
    logic          cache_branch_taken;
    logic          cache_evict = 1'b0;
    logic [15:0]   stat_resolved;
    logic [15:0]   stat_mispredict;
    logic [15:0]   stat_evict;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PW), .HIST_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
        .pred_out_valid(pred_out_valid), .pred_out_taken(pred_out_taken),
        .cache_rd_pc(cache_rd_pc), .cache_rd_history(cache_rd_history),
        .cache_rd_hit(cache_rd_hit),
        .res_valid(res_valid), .res_taken(res_taken), .res_err(res_err),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .cache_we(cache_we), .cache_upd_pc(cache_upd_pc),
        .cache_branch_taken(cache_branch_taken), .cache_evict(cache_evict),
        .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict),
        .stat_evict(stat_evict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: an ordered list of in-flight branches plus expected pulses.
    bru_entry_t mq[$];
    bit          e_pv, e_pt, e_we, e_bt, e_mp, e_err;
    logic [PW-1:0] e_upd, e_mpc;
    int          e_sr, e_sm, e_se;
    int          m_n, m_ones;
    bit          m_acc, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            {e_pv, e_pt, e_we, e_bt, e_mp, e_err} = '0;
            e_upd = '0;
            e_mpc = '0;
            e_sr = 0; e_sm = 0; e_se = 0;
        end else begin
            m_n = mq.size();
            m_acc = pred_req && (m_n < DEPTH);
            m_ones = 0;
            for (int i = 0; i < 3; i++) m_ones += int'(cache_rd_history[i]);
            if (e_we && cache_evict && e_se < 65535) e_se++;
            e_pv = m_acc;
            e_pt = m_acc && cache_rd_hit && (m_ones >= 2);
            e_we = 1'b0;
            e_mp = 1'b0;
            e_err = 1'b0;
            m_flush = 1'b0;
            if (res_valid && m_n == 0) begin
                e_err = 1'b1;
            end else if (res_valid) begin
                e_we = 1'b1;
                e_upd = mq[0].pc;
                e_bt = res_taken;
                if (e_sr < 65535) e_sr++;
                if (res_taken != mq[0].predicted) begin
                    e_mp = 1'b1;
                    e_mpc = mq[0].pc;
                    m_flush = 1'b1;
                    if (e_sm < 65535) e_sm++;
                end
                void'(mq.pop_front());
            end
            if (m_flush) mq.delete();
            else if (m_acc) mq.push_back('{pc: pred_pc, predicted: e_pt});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pred_ready", 32'(pred_ready),
                32'(rst_n && mq.size() < DEPTH));
            chk("pred_out_valid", 32'(pred_out_valid), 32'(e_pv));
            chk("pred_out_taken", 32'(pred_out_taken), 32'(e_pt));
            chk("cache_we", 32'(cache_we), 32'(e_we));
            chk("res_err", 32'(res_err), 32'(e_err));
            chk("mispredict", 32'(mispredict), 32'(e_mp));
            chk("cache_rd_pc", 32'(cache_rd_pc), 32'(pred_pc));
            if (e_we) begin
                chk("cache_upd_pc", 32'(cache_upd_pc), 32'(e_upd));
                chk("cache_branch_taken", 32'(cache_branch_taken), 32'(e_bt));
            end
            if (e_mp) chk("mispredict_pc", 32'(mispredict_pc), 32'(e_mpc));
`ifdef BRU_STATS_EN
            chk("stat_resolved", 32'(stat_resolved), 32'(e_sr));
            chk("stat_mispredict", 32'(stat_mispredict), 32'(e_sm));
            chk("stat_evict", 32'(stat_evict), 32'(e_se));
`else
            chk("stat_resolved", 32'(stat_resolved), 32'd0);
            chk("stat_mispredict", 32'(stat_mispredict), 32'd0);
            chk("stat_evict", 32'(stat_evict), 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [PW-1:0] pc, input logic [2:0] h,
                        input logic hit);
        pred_req = 1'b1;
        pred_pc = pc;
        cache_rd_history = h;
        cache_rd_hit = hit;
        step();
        pred_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk_en = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst pred_ready", 32'(pred_ready), 32'd0);
        step();
        step();
        chk("rst pred_out_valid", 32'(pred_out_valid), 32'd0);
        chk("rst cache_we", 32'(cache_we), 32'd0);
        rst_n = 1'b1;

        push(10'h013, 3'b011, 1'b1);
        chk("t1 valid", 32'(pred_out_valid), 32'd1);
        chk("t1 taken", 32'(pred_out_taken), 32'd1);
        step();
        chk("t1 valid drop", 32'(pred_out_valid), 32'd0);

        push(10'h014, 3'b111, 1'b0);
        chk("t2 valid", 32'(pred_out_valid), 32'd1);
        chk("t2 taken", 32'(pred_out_taken), 32'd0);

        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        chk("drain upd_pc", 32'(cache_upd_pc), 32'h014);
        chk("drain no mp", 32'(mispredict), 32'd0);

        for (int i = 0; i < 4; i++) push(PW'(10'h100 + i), 3'b000, 1'b0);
        chk("full ready", 32'(pred_ready), 32'd0);
        pred_req = 1'b1; pred_pc = 10'h104;
        step();
        chk("full no accept", 32'(pred_out_valid), 32'd0);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        chk("no bypass", 32'(pred_out_valid), 32'd0);
        chk("no bypass we", 32'(cache_we), 32'd1);
        chk("no bypass ready", 32'(pred_ready), 32'd1);
        res_valid = 1'b0;
        step();
        chk("accept after pop", 32'(pred_out_valid), 32'd1);
        pred_req = 1'b0;
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        chk("flush mp", 32'(mispredict), 32'd1);
        chk("flush mp_pc", 32'(mispredict_pc), 32'h101);
        chk("flush ready", 32'(pred_ready), 32'd1);

        push(10'h020, 3'b110, 1'b1);
        push(10'h021, 3'b000, 1'b1);
        push(10'h022, 3'b000, 1'b0);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        chk("mp we", 32'(cache_we), 32'd1);
        chk("mp upd_pc", 32'(cache_upd_pc), 32'h020);
        chk("mp taken", 32'(cache_branch_taken), 32'd0);
        chk("mp pulse", 32'(mispredict), 32'd1);
        chk("mp pc", 32'(mispredict_pc), 32'h020);
        step();
        res_valid = 1'b0;
        chk("empty err", 32'(res_err), 32'd1);
        chk("empty no we", 32'(cache_we), 32'd0);

        do_reset();
        push(10'h030, 3'b000, 1'b0);
        push(10'h031, 3'b000, 1'b0);
        push(10'h032, 3'b000, 1'b0);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        step();
        cache_evict = 1'b1;
        step();
        cache_evict = 1'b0;
        res_valid = 1'b0;
        step();
`ifdef BRU_STATS_EN
        chk("stat resolved", 32'(stat_resolved), 32'd3);
        chk("stat mispredict", 32'(stat_mispredict), 32'd0);
        chk("stat evict", 32'(stat_evict), 32'd1);
`else
        chk("stat resolved", 32'(stat_resolved), 32'd0);
        chk("stat mispredict", 32'(stat_mispredict), 32'd0);
        chk("stat evict", 32'(stat_evict), 32'd0);
`endif

        push(10'h040, 3'b111, 1'b1);
        push(10'h041, 3'b111, 1'b1);
        res_valid = 1'b1; res_taken = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(pred_out_valid), 32'd0);
        chk("arst ready", 32'(pred_ready), 32'd0);
        chk("arst we", 32'(cache_we), 32'd0);
        chk("arst stat", 32'(stat_resolved), 32'd0);
        step();
        chk("arst hold we", 32'(cache_we), 32'd0);
        rst_n = 1'b1;
        step();
        res_valid = 1'b0;
        chk("post rst err", 32'(res_err), 32'd1);
        chk("post rst we", 32'(cache_we), 32'd0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
